// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the external byte-port arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      IDLE,
      IC_RD,
      LS_RD,
      LS_WR
   } state_t;

   typedef enum logic {
      GR_IC,
      GR_LS
   } grant_t;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;
endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle: icache refill and load/store buffer channels.
interface mem_arbiter_if #(
   parameter int LINE_BYTES = 4
);
   logic                    ic_req;
   logic [31:0]             ic_addr;
   logic                    ic_done;
   logic [8*LINE_BYTES-1:0] ic_data;
   logic                    ls_req;
   logic                    ls_wr;
   logic [2:0]              ls_size;
   logic [31:0]             ls_addr;
   logic [31:0]             ls_wdata;
   logic                    ls_done;
   logic [31:0]             ls_rdata;

   modport master (
      output ic_req, ic_addr,
      output ls_req, ls_wr, ls_size,
      output ls_addr, ls_wdata,
      input  ic_done, ic_data,
      input  ls_done, ls_rdata
   );

   modport slave (
      input  ic_req, ic_addr,
      input  ls_req, ls_wr, ls_size,
      input  ls_addr, ls_wdata,
      output ic_done, ic_data,
      output ls_done, ls_rdata
   );
endinterface

// File: rtl/mem_arbiter_seq.sv
// Byte counter plus assembly (reads) / shift-out (writes) register.
module mem_arbiter_seq #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         load,
   input  logic         adv,
   input  logic         cap,
   input  logic [31:0]  wdata,
   input  logic [7:0]   din,
   output logic [4:0]   cnt,
   output logic [W-1:0] data,
   output logic [W-1:0] nxt
);
   logic [4:0] idx;

   assign idx = cnt - 5'd1;

   always_comb begin
      nxt = data;
      if (cap)
         nxt[8*int'(idx) +: 8] = din;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         data <= '0;
      end else if (en) begin
         if (load) begin
            cnt  <= '0;
            data <= W'(wdata);
         end else if (adv) begin
            cnt  <= cnt + 5'd1;
            data <= cap ? nxt : (data >> 8);
         end
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Owns the byte-wide RAM/IO port; serialises icache refills and
// lsb loads/stores into byte transactions.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int          IC_LINE_BYTES = 4,
   parameter logic [31:0] IO_BASE       = IO_BASE_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         rdy,
   input  logic [7:0]   mem_din,
   output logic [7:0]   mem_dout,
   output logic [31:0]  mem_a,
   output logic         mem_wr,
   input  logic         io_buffer_full,
   input  logic         rollback,
   mem_arbiter_if.slave bus
);
   localparam int W = 8 * IC_LINE_BYTES;

   state_t      state;
   grant_t      last;
   logic [4:0]  nbytes;
   logic [4:0]  cnt;
   logic        wr_q;
   logic        io_q;
   logic        ic_done_q;
   logic        ls_done_q;
   logic [W-1:0] ic_data_q;
   logic [31:0] ls_rdata_q;
   logic [W-1:0] sdata;
   logic [W-1:0] snxt;
   logic        frz;
   logic [7:0]  held;
   logic [7:0]  din;
   logic        ic_ok, ls_ok, go, pick_ls;
   logic        g_ic, g_ld, g_st;
   logic        io_now, io_hold, rd;
   logic        adv, cap;
   logic [31:0] ldata;

   // RAM keeps answering during a freeze; keep the byte that belongs
   // to the last active address so resume sees the right data.
   assign din = frz ? held : mem_din;

   always_ff @(posedge clk) begin
      if (rst) begin
         frz  <= 1'b0;
         held <= '0;
      end else begin
         frz <= !rdy;
         if (!rdy && !frz)
            held <= mem_din;
      end
   end

   always_comb begin
      ic_ok   = bus.ic_req && !ic_done_q && !rollback;
      ls_ok   = bus.ls_req && !ls_done_q
                && (bus.ls_wr || !rollback);
      go      = (state == IDLE) && (ic_ok || ls_ok);
      pick_ls = ls_ok && (!ic_ok || last == GR_IC);
      g_st    = go && pick_ls && bus.ls_wr;
      g_ld    = go && pick_ls && !bus.ls_wr;
      g_ic    = go && !pick_ls;
      io_now  = bus.ls_addr >= IO_BASE;
      io_hold = io_q && io_buffer_full;
      rd      = (state == IC_RD) || (state == LS_RD);
      ldata   = g_st ? bus.ls_wdata : '0;
      cap     = rd && !rollback && cnt != 5'd0;
      adv     = (rd && !rollback)
                || (state == LS_WR && wr_q
                    && cnt != nbytes - 5'd1);
   end

   mem_arbiter_seq #(.W(W)) u_seq (
      .clk   (clk),
      .rst   (rst),
      .en    (rdy),
      .load  (go),
      .adv   (adv),
      .cap   (cap),
      .wdata (ldata),
      .din   (din),
      .cnt   (cnt),
      .data  (sdata),
      .nxt   (snxt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last       <= GR_IC;
         mem_a      <= '0;
         mem_dout   <= '0;
         wr_q       <= FALSE;
         io_q       <= FALSE;
         nbytes     <= '0;
         ic_done_q  <= FALSE;
         ls_done_q  <= FALSE;
         ic_data_q  <= '0;
         ls_rdata_q <= '0;
      end else if (rdy) begin
         ic_done_q <= FALSE;
         ls_done_q <= FALSE;
         unique case (state)
            IDLE: begin
               unique case (1'b1)
                  g_st: begin
                     state    <= LS_WR;
                     last     <= GR_LS;
                     mem_a    <= bus.ls_addr;
                     mem_dout <= bus.ls_wdata[7:0];
                     io_q     <= io_now;
                     wr_q     <= !(io_now && io_buffer_full);
                     nbytes   <= {2'b00, bus.ls_size};
                  end
                  g_ld: begin
                     state  <= LS_RD;
                     last   <= GR_LS;
                     mem_a  <= bus.ls_addr;
                     nbytes <= {2'b00, bus.ls_size};
                  end
                  g_ic: begin
                     state  <= IC_RD;
                     last   <= GR_IC;
                     mem_a  <= bus.ic_addr;
                     nbytes <= 5'(IC_LINE_BYTES);
                  end
                  default: ;
               endcase
            end
            IC_RD, LS_RD: begin
               if (rollback) begin
                  state <= IDLE;
                  mem_a <= '0;
               end else begin
                  mem_a <= (cnt < nbytes - 5'd1) ?
                           mem_a + 32'd1 : '0;
                  if (cnt == nbytes) begin
                     state <= IDLE;
                     if (state == IC_RD) begin
                        ic_done_q <= TRUE;
                        ic_data_q <= snxt;
                     end else begin
                        ls_done_q  <= TRUE;
                        ls_rdata_q <= snxt[31:0];
                     end
                  end
               end
            end
            LS_WR: begin
               if (wr_q) begin
                  if (cnt == nbytes - 5'd1) begin
                     state     <= IDLE;
                     wr_q      <= FALSE;
                     mem_a     <= '0;
                     mem_dout  <= '0;
                     ls_done_q <= TRUE;
                  end else begin
                     mem_a    <= mem_a + 32'd1;
                     mem_dout <= sdata[15:8];
                     wr_q     <= !io_hold;
                  end
               end else if (!io_hold) begin
                  wr_q <= TRUE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign mem_wr       = wr_q && rdy;
   assign bus.ic_done  = ic_done_q;
   assign bus.ic_data  = ic_data_q;
   assign bus.ls_done  = ls_done_q;
   assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small read-only RAM model.
module tb_mem_arbiter;
   logic        clk;
   logic        rst;
   logic        rdy;
   logic [7:0]  mem_din;
   logic [7:0]  mem_dout;
   logic [31:0] mem_a;
   logic        mem_wr;
   logic        io_full;
   logic        rollback;
   logic [7:0]  ram [0:4095];
   int          passed;
   int          total;
   logic [31:0] wd;

   mem_arbiter_if #(.LINE_BYTES(4)) bus ();

   mem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .mem_din        (mem_din),
      .mem_dout       (mem_dout),
      .mem_a          (mem_a),
      .mem_wr         (mem_wr),
      .io_buffer_full (io_full),
      .rollback       (rollback),
      .bus            (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      mem_din <= ram[mem_a[11:0]];

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag,
                      input logic [127:0] obs,
                      input logic [127:0] exp_v);
      total++;
      assert (obs === exp_v) passed++;
      else $error("FAIL %s: observed %0h expected %0h",
                  tag, obs, exp_v);
   endtask

   initial begin
      passed = 0;
      total  = 0;
      for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
      ram[12'h100] = 8'h13; ram[12'h101] = 8'h05;
      ram[12'h102] = 8'h10; ram[12'h103] = 8'h00;
      ram[12'h110] = 8'hAA; ram[12'h111] = 8'hBB;
      ram[12'h112] = 8'hCC; ram[12'h113] = 8'hDD;
      ram[12'h120] = 8'h34; ram[12'h121] = 8'h12;
      ram[12'h140] = 8'h11; ram[12'h141] = 8'h22;
      ram[12'h142] = 8'h33; ram[12'h143] = 8'h44;
      rst = 1; rdy = 1; io_full = 0; rollback = 0;
      bus.ic_req = 0; bus.ic_addr = 0;
      bus.ls_req = 0; bus.ls_wr = 0; bus.ls_size = 0;
      bus.ls_addr = 0; bus.ls_wdata = 0;
      step(2);
      chk("rst_a", mem_a, 0);
      chk("rst_wr", mem_wr, 0);
      chk("rst_dout", mem_dout, 0);
      chk("rst_icd", bus.ic_done, 0);
      chk("rst_lsd", bus.ls_done, 0);
      chk("rst_icdata", bus.ic_data, 0);
      chk("rst_rdata", bus.ls_rdata, 0);
      rst = 0;
      step();

      // icache refill
      bus.ic_req = 1; bus.ic_addr = 32'h100;
      for (int k = 1; k <= 6; k++) begin
         step();
         chk("t1_wr", mem_wr, 0);
         if (k <= 4) chk("t1_a", mem_a, 32'h100 + k - 1);
         if (k < 6) chk("t1_early", bus.ic_done, 0);
      end
      chk("t1_done", bus.ic_done, 1);
      chk("t1_data", bus.ic_data, 32'h0010_0513);
      bus.ic_req = 0;
      step();
      chk("t1_pulse", bus.ic_done, 0);

      // 4-byte store
      wd = 32'hDEAD_BEEF;
      bus.ls_req = 1; bus.ls_wr = 1; bus.ls_size = 4;
      bus.ls_addr = 32'h200; bus.ls_wdata = wd;
      for (int k = 1; k <= 4; k++) begin
         step();
         chk("t2_wr", mem_wr, 1);
         chk("t2_a", mem_a, 32'h200 + k - 1);
         chk("t2_dout", mem_dout, wd[8*(k-1) +: 8]);
         chk("t2_early", bus.ls_done, 0);
      end
      step();
      chk("t2_done", bus.ls_done, 1);
      chk("t2_wr_end", mem_wr, 0);
      chk("t2_a_end", mem_a, 0);
      bus.ls_req = 0; bus.ls_wr = 0;
      step();
      chk("t2_pulse", bus.ls_done, 0);

      // simultaneous requests after reset: lsb wins, icache back-to-back
      rst = 1;
      step();
      rst = 0;
      bus.ic_req = 1; bus.ic_addr = 32'h100;
      bus.ls_req = 1; bus.ls_wr = 0; bus.ls_size = 2;
      bus.ls_addr = 32'h120;
      step();
      chk("t3_a_ls", mem_a, 32'h120);
      step(2);
      chk("t3_a_off", mem_a, 0);
      chk("t3_early", bus.ls_done, 0);
      step();
      chk("t3_lsdone", bus.ls_done, 1);
      chk("t3_rdata", bus.ls_rdata, 32'h0000_1234);
      bus.ls_req = 0;
      step();
      chk("t3_a_ic", mem_a, 32'h100);
      chk("t3_lspulse", bus.ls_done, 0);
      step(4);
      chk("t3_icearly", bus.ic_done, 0);
      step();
      chk("t3_icdone", bus.ic_done, 1);
      chk("t3_icdata", bus.ic_data, 32'h0010_0513);
      bus.ic_req = 0;
      step();

      // rollback two cycles into a refill
      bus.ic_req = 1; bus.ic_addr = 32'h110;
      step();
      chk("t4_a0", mem_a, 32'h110);
      step();
      chk("t4_a1", mem_a, 32'h111);
      rollback = 1; bus.ic_req = 0;
      step();
      chk("t4_a_rb", mem_a, 0);
      chk("t4_nodone", bus.ic_done, 0);
      rollback = 0;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t4_quiet", bus.ic_done, 0);
      end
      bus.ic_req = 1;
      step(5);
      chk("t4_early", bus.ic_done, 0);
      step();
      chk("t4_done", bus.ic_done, 1);
      chk("t4_data", bus.ic_data, 32'hDDCC_BBAA);
      bus.ic_req = 0;
      step();

      // store granted despite rollback; rollback ignored mid-store
      rollback = 1;
      bus.ls_req = 1; bus.ls_wr = 1; bus.ls_size = 1;
      bus.ls_addr = 32'h210; bus.ls_wdata = 32'h0000_0055;
      step();
      chk("t5_wr", mem_wr, 1);
      chk("t5_a", mem_a, 32'h210);
      chk("t5_dout", mem_dout, 8'h55);
      step();
      chk("t5_done", bus.ls_done, 1);
      chk("t5_wr_end", mem_wr, 0);
      rollback = 0; bus.ls_req = 0;
      step();

      // IO store held off by a full UART buffer
      io_full = 1;
      bus.ls_req = 1; bus.ls_wr = 1; bus.ls_size = 1;
      bus.ls_addr = 32'h0003_0000; bus.ls_wdata = 32'h41;
      for (int k = 1; k <= 5; k++) begin
         step();
         chk("t6_hold_wr", mem_wr, 0);
         chk("t6_hold_done", bus.ls_done, 0);
      end
      io_full = 0;
      step();
      chk("t6_wr", mem_wr, 1);
      chk("t6_a", mem_a, 32'h0003_0000);
      chk("t6_dout", mem_dout, 8'h41);
      chk("t6_early", bus.ls_done, 0);
      step();
      chk("t6_done", bus.ls_done, 1);
      chk("t6_wr_end", mem_wr, 0);
      bus.ls_req = 0; bus.ls_wr = 0;
      step();

      // freeze for three cycles mid-refill
      bus.ic_req = 1; bus.ic_addr = 32'h140;
      step(2);
      chk("t7_a1", mem_a, 32'h141);
      step();
      rdy = 0;
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("t7_frz_a", mem_a, 32'h142);
         chk("t7_frz_wr", mem_wr, 0);
         chk("t7_frz_done", bus.ic_done, 0);
         step();
      end
      rdy = 1;
      step(2);
      chk("t7_early", bus.ic_done, 0);
      step();
      chk("t7_done", bus.ic_done, 1);
      chk("t7_data", bus.ic_data, 32'h4433_2211);
      bus.ic_req = 0;
      step();
      chk("t7_pulse", bus.ic_done, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
